// File: rtl/gcd_core.sv
// +----------------------------------------------------------------------------+
// | gcd_core: 16-bit subtractive GCD engine with operand-select muxes and FSM   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module gcd_mux2 #(
  parameter int WIDTH = 16
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

module gcd_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] gcd_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] w_diff;
  logic             w_sel;
  logic             w_a_zero;
  logic             w_b_zero;
  logic             w_a_eq_b;
  logic             w_a_gt_b;
  logic             w_finish;
  logic             w_accept;
  logic             w_step;
  logic             w_load_a;
  logic             w_load_b;

  assign w_a_zero = (a_q == '0);
  assign w_b_zero = (b_q == '0);
  assign w_a_eq_b = (a_q == b_q);
  assign w_a_gt_b = (a_q > b_q);
  assign w_finish = w_a_zero | w_b_zero | w_a_eq_b;

  // Always larger minus smaller, so the result never wraps.
  assign w_diff   = w_a_gt_b ? (a_q - b_q) : (b_q - a_q);

  assign w_accept = (state_q == S_IDLE) & start;
  assign w_step   = (state_q == S_CALC) & ~w_finish;
  assign w_sel    = (state_q == S_CALC);
  assign w_load_a = w_accept | (w_step & w_a_gt_b);
  assign w_load_b = w_accept | (w_step & ~w_a_gt_b);

  gcd_mux2 #(.WIDTH(WIDTH)) u_mux_a (
    .sel_i (w_sel),
    .d0_i  (a_in),
    .d1_i  (w_diff),
    .y_o   (a_d)
  );

  gcd_mux2 #(.WIDTH(WIDTH)) u_mux_b (
    .sel_i (w_sel),
    .d0_i  (b_in),
    .d1_i  (w_diff),
    .y_o   (b_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (w_load_a) a_q <= a_d;
      if (w_load_b) b_q <= b_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gcd_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CALC;
            busy_q  <= 1'b1;
          end
        end
        S_CALC: begin
          if (w_finish) begin
            gcd_q   <= w_a_zero ? b_q : a_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign gcd_out = gcd_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_core.sv
// Directed self-checking bench for gcd_core: latency, results, reset and start handling.
`default_nettype none

module tb_gcd_core;

  localparam int WIDTH = 16;
  localparam int LIMIT = 70000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] gcd_out;

  int checks   = 0;
  int failures = 0;

  gcd_core #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .gcd_out (gcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and measure latency (clocks from accepting edge to done) and busy cycles.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = busy ? 1 : 0;
    lat = 0;
    while (lat < LIMIT) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || gcd_out !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b gcd=%0d, want 0 0 0", busy, done, gcd_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int lat, bc;
    run_op(16'd12, 16'd8, lat, bc);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 3", lat);
    end
    checks++;
    if (gcd_out !== 16'd4) begin
      failures++;
      $display("FAIL basic_result: got %0d want 4", gcd_out);
    end
    checks++;
    if (bc !== 3) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d want 3", bc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || gcd_out !== 16'd4) begin
      failures++;
      $display("FAIL basic_done_pulse: done=%b gcd=%0d, want 0 4", done, gcd_out);
    end
  endtask

  task automatic test_zero_equal;
    logic [WIDTH-1:0] va [4];
    logic [WIDTH-1:0] vb [4];
    logic [WIDTH-1:0] vr [4];
    int lat, bc;
    va[0] = 16'd0;  vb[0] = 16'd0;  vr[0] = 16'd0;
    va[1] = 16'd0;  vb[1] = 16'd25; vr[1] = 16'd25;
    va[2] = 16'd37; vb[2] = 16'd0;  vr[2] = 16'd37;
    va[3] = 16'd9;  vb[3] = 16'd9;  vr[3] = 16'd9;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, bc);
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("FAIL zero_eq_latency[%0d]: got %0d want 1", i, lat);
      end
      checks++;
      if (gcd_out !== vr[i]) begin
        failures++;
        $display("FAIL zero_eq_result[%0d]: got %0d want %0d", i, gcd_out, vr[i]);
      end
    end
  endtask

  task automatic test_reset_mid_calc;
    int lat, bc;
    // gcd_out currently holds 9 from the previous test.
    @(negedge clk);
    a_in = 16'd48; b_in = 16'd18; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || gcd_out !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b gcd=%0d, want 0 0 0", busy, done, gcd_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) bc++;
    end
    checks++;
    if (bc !== 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d done pulses want 0", bc);
    end
    run_op(16'd48, 16'd18, lat, bc);
    checks++;
    if (lat !== 5 || gcd_out !== 16'd6) begin
      failures++;
      $display("FAIL reset_restart: lat=%0d gcd=%0d, want 5 6", lat, gcd_out);
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    a_in = 16'd270; b_in = 16'd192; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (lat < LIMIT) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        a_in = 16'd5; b_in = 16'd10; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    checks++;
    if (lat !== 11) begin
      failures++;
      $display("FAIL busy_start_latency: got %0d want 11", lat);
    end
    checks++;
    if (gcd_out !== 16'd6) begin
      failures++;
      $display("FAIL busy_start_result: got %0d want 6", gcd_out);
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back;
    int lat;
    bit held;
    @(negedge clk);
    a_in = 16'd21; b_in = 16'd14; start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (lat < LIMIT) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    checks++;
    if (lat !== 3 || gcd_out !== 16'd7) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d gcd=%0d, want 3 7", lat, gcd_out);
    end
    // start still high: the second request is taken on this done cycle.
    a_in = 16'd17; b_in = 16'd5;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
    end
    held = 1'b1;
    lat = 0;
    while (lat < LIMIT) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (gcd_out !== 16'd7) held = 1'b0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL b2b_hold: gcd_out changed before second done, want 7 held");
    end
    checks++;
    if (lat !== 7 || gcd_out !== 16'd1) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d gcd=%0d, want 7 1", lat, gcd_out);
    end
  endtask

  task automatic test_worst_case;
    int lat, bc;
    run_op(16'd65535, 16'd1, lat, bc);
    checks++;
    if (lat !== 65535) begin
      failures++;
      $display("FAIL worst_latency: got %0d want 65535", lat);
    end
    checks++;
    if (gcd_out !== 16'd1) begin
      failures++;
      $display("FAIL worst_result: got %0d want 1", gcd_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_equal();
    test_reset_mid_calc();
    test_start_while_busy();
    test_back_to_back();
    test_worst_case();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gcd_core.md
# gcd_core

Sequential 16-bit greatest-common-divisor engine for the GCD datapath, using repeated subtraction. It holds two operand registers A and B. The 16-bit 2:1 `MUX` cells sit directly upstream of those registers and select between the external operands and the subtractor result. gcd_core owns the control FSM that drives those selects, plus the subtract/compare logic. It accepts an operand pair on a start pulse and returns the result with a one-cycle done strobe.

## Interface
- WIDTH, 16, operand and result width in bits.

- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; one clock, no other reset.
- start  input  1  request; sampled on the rising edge only while the FSM is in IDLE.
- a_in  input  WIDTH  operand A, unsigned; sampled on the accepting edge only.
- b_in  input  WIDTH  operand B, unsigned; sampled on the accepting edge only.
- busy  output  1  high while state is CALC.
- done  output  1  registered, one-cycle pulse when gcd_out is updated.
- gcd_out  output  WIDTH  last result; holds until the next completion.

## Operation
- States: IDLE, CALC. Encoding is free.
- Operand-register muxes:
  - In IDLE with start=1: sel=0, so A<=a_in, B<=b_in and the FSM moves to CALC.
  - In CALC: the selected register takes the difference; the other register holds.
- Each CALC cycle evaluates the following, in priority order:
  1. A==0 or B==0 or A==B: gcd_out<=(A==0 ? B : A), done<=1, go to IDLE. This gives gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0.
  2. A>B: A<=A-B.
  3. Otherwise: B<=B-A.
- Arithmetic is unsigned, WIDTH bits. The subtraction is always larger minus smaller, so no underflow or wrap is possible. No carry-out is kept.
- start while busy: ignored. It does not restart, does not reload operands and raises no error.
- start in the cycle done is high: the FSM is already in IDLE, so it is accepted and a new computation begins on that edge.
- A and B registers hold their values in IDLE. Their contents are not visible at the outputs.
- Reset (async, any time including mid-CALC):
  - State goes to IDLE.
  - A, B and gcd_out go to 0; busy and done go to 0.
  - Any computation in flight is discarded; no done pulse is produced.
  - The first start after rst_n deasserts is accepted normally.

## Timing
- Accepting edge E0 (start=1 in IDLE): operands are loaded and busy goes high in the following cycle.
- Let S = number of subtraction steps. Edges E1..ES each perform one subtraction.
- Edge E(S+1) is the termination edge:
  - gcd_out is updated, done=1 and busy=0 during the cycle after E(S+1).
  - At E(S+2), done returns to 0 unless that cycle also completes a computation, which is impossible because CALC lasts at least one cycle.
- Latency from the accepting edge to done high is S+1 clocks.
  - Minimum is 1 (equal or zero operands).
  - Maximum for WIDTH=16 is 65535 (operands 65535 and 1: S=65534).
- Throughput: back-to-back requests are possible with no idle gap. start held high across done restarts on the done cycle.
- The busy and done registers are cleared by rst_n asynchronously, with no clock required.

## Test plan
- Reset: assert rst_n=0 mid-CALC of (48,18) -> busy=0, done=0 and gcd_out=0 immediately. After release, no done pulse appears; a fresh start of (48,18) returns 6.
- Basic: start with (12,8) -> S=2 (12,8 -> 4,8 -> 4,4). done is high exactly 3 clocks after the accepting edge, for one cycle, with gcd_out=4. busy is high for 3 cycles.
- Zero and equal operands, each with latency 1 clock:
  - (0,0) -> 0.
  - (0,25) -> 25.
  - (37,0) -> 37.
  - (9,9) -> 9.
- Worst case: (65535,1) -> gcd_out=1 after 65535 clocks. A and B never exceed their load values.
- start while busy: start with (270,192), then pulse start with (5,10) during CALC -> the second request is ignored, gcd_out=6 at the normal latency.
- Back-to-back: hold start high with (21,14) then (17,5) presented on the done cycle -> results 7 and then 1. The second start is accepted on the first done cycle. gcd_out holds 7 until the second done.
